// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants, RGB565 payload type, mode/state encodings and
// colour-bar lookup for the LCD test-pattern generator.
package lcd_pkg;

  // Default active geometry and bar/checker cell width
  localparam int unsigned DEF_H_ACT = 640;
  localparam int unsigned DEF_V_ACT = 480;
  localparam int unsigned DEF_BAR_W = 80;

  // Coordinate width from the timing stage
  localparam int unsigned COORD_W = 10;

  // RGB565 pixel payload
  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // Colour-bar palette
  localparam rgb565_t C_WHITE   = '{r: 5'd31, g: 6'd63, b: 5'd31};
  localparam rgb565_t C_YELLOW  = '{r: 5'd31, g: 6'd63, b: 5'd0};
  localparam rgb565_t C_CYAN    = '{r: 5'd0,  g: 6'd63, b: 5'd31};
  localparam rgb565_t C_GREEN   = '{r: 5'd0,  g: 6'd63, b: 5'd0};
  localparam rgb565_t C_MAGENTA = '{r: 5'd31, g: 6'd0,  b: 5'd31};
  localparam rgb565_t C_RED     = '{r: 5'd31, g: 6'd0,  b: 5'd0};
  localparam rgb565_t C_BLUE    = '{r: 5'd0,  g: 6'd0,  b: 5'd31};
  localparam rgb565_t C_BLACK   = '{r: 5'd0,  g: 6'd0,  b: 5'd0};

  // Displayed pattern encoding
  typedef enum logic [1:0] {
    MODE_BARS   = 2'd0,
    MODE_CHECK  = 2'd1,
    MODE_GRAD   = 2'd2,
    MODE_BORDER = 2'd3
  } mode_e;

  // Control FSM: blank until the first frame start, then run
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Map a bar index (0..7, left to right) to its colour
  function automatic rgb565_t bar_colour(input logic [2:0] idx);
    rgb565_t c;
    case (idx)
      3'd0:    c = C_WHITE;
      3'd1:    c = C_YELLOW;
      3'd2:    c = C_CYAN;
      3'd3:    c = C_GREEN;
      3'd4:    c = C_MAGENTA;
      3'd5:    c = C_RED;
      3'd6:    c = C_BLUE;
      default: c = C_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_sync_edge.sv
// lcd_sync_edge: falling-edge detector for an active-low sync; o_fall_c is
// high in the cycle the sync is first seen low (frame start for vsync).
module lcd_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sync,
  output logic o_fall_c
);

  logic r_sync_d;

  // Previous sync level; idles high so reset never fakes an edge from a high sync
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync_d <= 1'b1;
    else        r_sync_d <= i_sync;
  end

  assign o_fall_c = r_sync_d & ~i_sync;

endmodule

// File: rtl/lcd_pattern_gen.sv
// lcd_pattern_gen: test-pattern source between LCD timing and panel pins.
// Two-cycle pipeline on de/hsy/vsy/rgb; pattern advances on frame start after
// a mode_next request. Optional macro LCD_PAT_SCROLL_EN adds a frame counter
// that scrolls the bar and checker patterns left one pixel per frame.
module lcd_pattern_gen
  import lcd_pkg::*;
#(
  parameter int unsigned H_ACT = DEF_H_ACT,
  parameter int unsigned V_ACT = DEF_V_ACT,
  parameter int unsigned BAR_W = DEF_BAR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               de_in,
  input  logic               hsy_in,
  input  logic               vsy_in,
  input  logic [COORD_W-1:0] x_in,
  input  logic [COORD_W-1:0] y_in,
  input  logic               mode_next,
  output logic               de_out,
  output logic               hsy_out,
  output logic               vsy_out,
  output logic [4:0]         lcd_r,
  output logic [5:0]         lcd_g,
  output logic [4:0]         lcd_b,
  output logic [1:0]         mode
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_ACT - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_ACT - 1);

  logic               w_frame_start;
  state_e             r_state, w_state_nxt;
  mode_e              r_mode, w_mode_nxt;
  logic               r_pending, w_pending_nxt;

  logic [COORD_W-1:0] w_x_cl, w_y_cl, w_x_pat, w_bar_x;
  logic [2:0]         w_bar_idx;
  logic               w_chk, w_border;
  rgb565_t            w_rgb;

  logic               r_de_s1, r_hsy_s1, r_vsy_s1;
  rgb565_t            r_rgb_s1;
  logic               r_de_s2, r_hsy_s2, r_vsy_s2;
  rgb565_t            r_rgb_s2;

  lcd_sync_edge u_vsy_edge (
    .clk      (clk),
    .rst_n    (rst),
    .i_sync   (vsy_in),
    .o_fall_c (w_frame_start)
  );

  // Clamp stray coordinates to the last active pixel/line
  assign w_x_cl = (x_in > X_LAST) ? X_LAST : x_in;
  assign w_y_cl = (y_in > Y_LAST) ? Y_LAST : y_in;

`ifdef LCD_PAT_SCROLL_EN
  logic [7:0]         r_frame_cnt;
  logic [COORD_W:0]   w_x_sum;

  // Frame counter drives the horizontal scroll offset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               r_frame_cnt <= 8'd0;
    else if (w_frame_start) r_frame_cnt <= r_frame_cnt + 8'd1;
  end

  // Single conditional subtract is a full modulo since H_ACT >= 256
  assign w_x_sum = (COORD_W+1)'(w_x_cl) + (COORD_W+1)'(r_frame_cnt);
  assign w_x_pat = (w_x_sum >= (COORD_W+1)'(H_ACT)) ?
                   COORD_W'(w_x_sum - (COORD_W+1)'(H_ACT)) : w_x_sum[COORD_W-1:0];
`else
  assign w_x_pat = w_x_cl;
`endif

  assign w_bar_x   = COORD_W'(32'(w_x_pat) / BAR_W);
  assign w_bar_idx = (w_bar_x > COORD_W'(7)) ? 3'd7 : w_bar_x[2:0];
  assign w_chk     = 1'((32'(w_x_pat) / BAR_W) ^ (32'(w_y_cl) / BAR_W));
  assign w_border  = (w_x_cl == '0) || (w_x_cl == X_LAST) ||
                     (w_y_cl == '0) || (w_y_cl == Y_LAST);

  // Pattern colour for the current input pixel
  always_comb begin
    w_rgb = C_BLACK;
    case (r_mode)
      MODE_BARS:   w_rgb = bar_colour(w_bar_idx);
      MODE_CHECK:  w_rgb = w_chk ? C_BLACK : C_WHITE;
      MODE_GRAD:   w_rgb = '{r: w_x_cl[9:5], g: w_x_cl[9:4], b: w_x_cl[9:5]};
      MODE_BORDER: w_rgb = w_border ? C_WHITE : C_BLUE;
      default:     w_rgb = C_BLACK;
    endcase
  end

  // Control state, mode and pending-request registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_mode    <= MODE_BARS;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mode    <= w_mode_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  // Next state: mode only moves at frame start, absorbing any queued request
  always_comb begin
    w_state_nxt   = r_state;
    w_mode_nxt    = r_mode;
    w_pending_nxt = r_pending | mode_next;
    if (w_frame_start) begin
      w_state_nxt   = ST_RUN;
      w_pending_nxt = 1'b0;
      if (r_pending | mode_next) w_mode_nxt = mode_e'(r_mode + 2'd1);
    end
  end

  // Two-stage video pipeline; de held low until running, rgb blanked without de
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_de_s1  <= 1'b0;
      r_hsy_s1 <= 1'b1;
      r_vsy_s1 <= 1'b1;
      r_rgb_s1 <= C_BLACK;
      r_de_s2  <= 1'b0;
      r_hsy_s2 <= 1'b1;
      r_vsy_s2 <= 1'b1;
      r_rgb_s2 <= C_BLACK;
    end else begin
      r_de_s1  <= de_in & (r_state == ST_RUN);
      r_hsy_s1 <= hsy_in;
      r_vsy_s1 <= vsy_in;
      r_rgb_s1 <= w_rgb;
      r_de_s2  <= r_de_s1;
      r_hsy_s2 <= r_hsy_s1;
      r_vsy_s2 <= r_vsy_s1;
      r_rgb_s2 <= r_de_s1 ? r_rgb_s1 : C_BLACK;
    end
  end

  assign de_out  = r_de_s2;
  assign hsy_out = r_hsy_s2;
  assign vsy_out = r_vsy_s2;
  assign lcd_r   = r_rgb_s2.r;
  assign lcd_g   = r_rgb_s2.g;
  assign lcd_b   = r_rgb_s2.b;
  assign mode    = r_mode;

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// tb_lcd_pattern_gen: directed self-checking bench for lcd_pattern_gen
// (default build, LCD_PAT_SCROLL_EN undefined).
module tb_lcd_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       de_in, hsy_in, vsy_in, mode_next;
  logic [9:0] x_in, y_in;
  logic       de_out, hsy_out, vsy_out;
  logic [4:0] lcd_r;
  logic [5:0] lcd_g;
  logic [4:0] lcd_b;
  logic [1:0] mode;

  int total = 0;
  int bad   = 0;

  logic de_a [40];
  logic hs_a [40];

  localparam logic [15:0] WHITE   = 16'hFFFF;
  localparam logic [15:0] YELLOW  = 16'hFFE0;
  localparam logic [15:0] CYAN    = 16'h07FF;
  localparam logic [15:0] GREEN   = 16'h07E0;
  localparam logic [15:0] MAGENTA = 16'hF81F;
  localparam logic [15:0] RED     = 16'hF800;
  localparam logic [15:0] BLUE    = 16'h001F;
  localparam logic [15:0] BLACK   = 16'h0000;

  lcd_pattern_gen dut (
    .clk       (clk),
    .rst       (rst),
    .de_in     (de_in),
    .hsy_in    (hsy_in),
    .vsy_in    (vsy_in),
    .x_in      (x_in),
    .y_in      (y_in),
    .mode_next (mode_next),
    .de_out    (de_out),
    .hsy_out   (hsy_out),
    .vsy_out   (vsy_out),
    .lcd_r     (lcd_r),
    .lcd_g     (lcd_g),
    .lcd_b     (lcd_b),
    .mode      (mode)
  );

  always #20 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rgb_of(input int r, input int g, input int b);
    return {5'(r), 6'(g), 5'(b)};
  endfunction

  // Present one active pixel and check it two cycles later
  task automatic pix(input string tag, input int x, input int y, input logic [15:0] exp);
    x_in  = 10'(x);
    y_in  = 10'(y);
    de_in = 1'b1;
    tick();
    tick();
    chk(tag, {lcd_r, lcd_g, lcd_b}, exp);
    chk({tag, "_de"}, 16'(de_out), 16'd1);
  endtask

  // Blanked vsync pulse producing one frame start
  task automatic frame_start();
    de_in  = 1'b0;
    vsy_in = 1'b0;
    tick();
    tick();
    vsy_in = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b0; de_in = 1'b0; hsy_in = 1'b1; vsy_in = 1'b1;
    x_in = '0; y_in = '0; mode_next = 1'b0;
    tick(); tick(); tick();

    // Reset values
    chk("rst_de",   16'(de_out),  16'd0);
    chk("rst_hsy",  16'(hsy_out), 16'd1);
    chk("rst_vsy",  16'(vsy_out), 16'd1);
    chk("rst_rgb",  {lcd_r, lcd_g, lcd_b}, BLACK);
    chk("rst_mode", 16'(mode), 16'd0);

    // IDLE: de blanked, syncs still delayed by two
    rst = 1'b1; de_in = 1'b1; x_in = 10'd0; y_in = 10'd10; hsy_in = 1'b0;
    tick();
    chk("idle_hsy_d1", 16'(hsy_out), 16'd1);
    tick();
    chk("idle_hsy_d2", 16'(hsy_out), 16'd0);
    chk("idle_de",     16'(de_out),  16'd0);
    chk("idle_rgb",    {lcd_r, lcd_g, lcd_b}, BLACK);
    hsy_in = 1'b1; de_in = 1'b0;
    tick(); tick();

    // First frame start; vsync delay
    vsy_in = 1'b0;
    tick();
    chk("vsy_d1", 16'(vsy_out), 16'd1);
    tick();
    chk("vsy_d2", 16'(vsy_out), 16'd0);
    vsy_in = 1'b1;
    tick(); tick();
    chk("vsy_back", 16'(vsy_out), 16'd1);

    // Mode 0: colour bars, including clamped x
    pix("bar0",      0, 10, WHITE);
    pix("bar0_end", 79, 10, WHITE);
    pix("bar1",     80, 10, YELLOW);
    pix("bar2",    160, 10, CYAN);
    pix("bar3",    240, 10, GREEN);
    pix("bar4",    320, 10, MAGENTA);
    pix("bar5",    400, 10, RED);
    pix("bar6",    480, 10, BLUE);
    pix("bar7",    560, 10, BLACK);
    pix("bar_last",639, 10, BLACK);
    pix("bar_clmp",1000,10, BLACK);

    // Three requests mid-frame: one increment, only at frame start
    for (int i = 0; i < 3; i++) begin
      mode_next = 1'b1;
      tick();
      mode_next = 1'b0;
      tick(); tick();
      chk("mode_hold", 16'(mode), 16'd0);
    end
    de_in = 1'b0;
    vsy_in = 1'b0;
    chk("mode_pre_edge", 16'(mode), 16'd0);
    tick();
    chk("mode_at_edge", 16'(mode), 16'd1);
    tick();
    vsy_in = 1'b1;
    tick(); tick();
    frame_start();
    chk("mode_no_repeat", 16'(mode), 16'd1);

    // Mode 1: checkerboard
    pix("chk_0_0",    0,  0, WHITE);
    pix("chk_80_0",  80,  0, BLACK);
    pix("chk_80_80", 80, 80, WHITE);
    pix("chk_0_80",   0, 80, BLACK);

    // Request coincident with vsync fall applies at that edge
    de_in = 1'b0;
    vsy_in = 1'b0;
    mode_next = 1'b1;
    tick();
    mode_next = 1'b0;
    chk("mode_coinc", 16'(mode), 16'd2);
    tick();
    vsy_in = 1'b1;
    tick(); tick();

    // Mode 2: gradient from upper x bits
    pix("grad_100", 100, 50, rgb_of(3, 6, 3));
    pix("grad_639", 639, 50, rgb_of(19, 39, 19));
    pix("grad_clmp",900, 50, rgb_of(19, 39, 19));

    // Mode 3: border
    mode_next = 1'b1;
    tick();
    mode_next = 1'b0;
    frame_start();
    chk("mode_3", 16'(mode), 16'd3);
    pix("brd_0_200",     0, 200, WHITE);
    pix("brd_1_200",     1, 200, BLUE);
    pix("brd_639_200", 639, 200, WHITE);
    pix("brd_xclmp",   700, 200, WHITE);
    pix("brd_5_0",       5,   0, WHITE);
    pix("brd_5_479",     5, 479, WHITE);
    pix("brd_yclmp",     5, 600, WHITE);
    pix("brd_inner",   638, 478, BLUE);

    // Random de/hsync: exact two-cycle delay and blanking
    x_in = 10'd5; y_in = 10'd200;
    for (int i = 0; i < 40; i++) begin
      de_a[i] = 1'($urandom_range(0, 1));
      hs_a[i] = 1'($urandom_range(0, 1));
      de_in  = de_a[i];
      hsy_in = hs_a[i];
      tick();
      if (i >= 1) begin
        chk("rnd_de",  16'(de_out),  16'(de_a[i-1]));
        chk("rnd_hsy", 16'(hsy_out), 16'(hs_a[i-1]));
        chk("rnd_vsy", 16'(vsy_out), 16'd1);
        chk("rnd_rgb", {lcd_r, lcd_g, lcd_b}, de_a[i-1] ? BLUE : BLACK);
      end
    end

    // Mid-frame reset at pixel 300 of line 100
    x_in = 10'd300; y_in = 10'd100; de_in = 1'b1; hsy_in = 1'b0;
    tick(); tick();
    chk("pre_rst_de",  16'(de_out),  16'd1);
    chk("pre_rst_hsy", 16'(hsy_out), 16'd0);
    chk("pre_rst_rgb", {lcd_r, lcd_g, lcd_b}, BLUE);
    @(posedge clk);
    #5;
    rst = 1'b0;
    #1;
    chk("arst_de",   16'(de_out),  16'd0);
    chk("arst_hsy",  16'(hsy_out), 16'd1);
    chk("arst_vsy",  16'(vsy_out), 16'd1);
    chk("arst_rgb",  {lcd_r, lcd_g, lcd_b}, BLACK);
    chk("arst_mode", 16'(mode), 16'd0);
    tick();
    rst = 1'b1;
    hsy_in = 1'b1;
    tick(); tick(); tick(); tick();
    chk("post_rst_de",  16'(de_out), 16'd0);
    chk("post_rst_rgb", {lcd_r, lcd_g, lcd_b}, BLACK);
    frame_start();
    pix("post_rst_bar3", 300, 100, GREEN);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
